// File: rtl/mehdi_debug_cmd_dispatch.sv
// mehdi_debug_cmd_dispatch
// System-clock side of the debug slave. Synchronises the JTAG update-DR and
// update-IR strobes, buffers {ir, sr} commands in a small FIFO and dispatches
// them one at a time as one-hot take_action / take_no_action pulses.
//
// Optional feature: define DBG_CMD_PARITY_EN to check sr against sr_par at
// capture; mismatching commands are dropped and flagged on parity_err.
// Without it, sr_par is ignored and parity_err is tied low.

module mehdi_debug_cmd_dispatch #(
   parameter int unsigned DATA_W      = 38,
   parameter int unsigned IR_W        = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ACTION_BIT  = 37
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              udr_async,
   input  logic                              uir_async,
   input  logic [IR_W-1:0]                   ir_in,
   input  logic [DATA_W-1:0]                 sr,
   input  logic                              sr_par,
   input  logic                              cmd_ready,
   input  logic                              err_clr,
   output logic [DATA_W-1:0]                 jdo,
   output logic [IR_W-1:0]                   jir,
   output logic [(2**IR_W)-1:0]              take_action,
   output logic [(2**IR_W)-1:0]              take_no_action,
   output logic                              uir_pulse,
   output logic [$clog2(FIFO_DEPTH):0]       cmd_level,
   output logic                              overflow,
   output logic                              parity_err
);

   localparam int unsigned NV    = 2**IR_W;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned ENT_W = IR_W + DATA_W;

   // ------------------------------------------------------------------
   // Strobe synchronisers
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] udr_sync;
   logic [SYNC_STAGES-1:0] uir_sync;
   logic [SYNC_STAGES-1:0] sync_fill;   // marks when sync outputs hold real samples
   logic                   udr_prev;
   logic                   uir_prev;
   logic                   udr_armed;
   logic                   uir_armed;
   logic                   udr_lvl_c;
   logic                   uir_lvl_c;
   logic                   udr_pulse_c;
   logic                   uir_pulse_c;

   assign udr_lvl_c = udr_sync[SYNC_STAGES-1];
   assign uir_lvl_c = uir_sync[SYNC_STAGES-1];

   // Synchroniser chains plus arming: a strobe only counts once a genuine low
   // sample has passed through the chain since reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         udr_sync  <= '0;
         uir_sync  <= '0;
         sync_fill <= '0;
         udr_prev  <= 1'b0;
         uir_prev  <= 1'b0;
         udr_armed <= 1'b0;
         uir_armed <= 1'b0;
      end else begin
         udr_sync  <= {udr_sync[SYNC_STAGES-2:0], udr_async};
         uir_sync  <= {uir_sync[SYNC_STAGES-2:0], uir_async};
         sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
         udr_prev  <= udr_lvl_c;
         uir_prev  <= uir_lvl_c;
         udr_armed <= udr_armed | (sync_fill[SYNC_STAGES-1] & ~udr_lvl_c);
         uir_armed <= uir_armed | (sync_fill[SYNC_STAGES-1] & ~uir_lvl_c);
      end
   end

   // Rising-edge detection on the synchronised levels.
   always_comb begin
      udr_pulse_c = udr_armed & udr_lvl_c & ~udr_prev;
      uir_pulse_c = uir_armed & uir_lvl_c & ~uir_prev;
   end

   // ------------------------------------------------------------------
   // Capture qualification
   // ------------------------------------------------------------------
   logic par_ok_c;

`ifdef DBG_CMD_PARITY_EN
   // Even parity over sr must match the supplied parity bit.
   always_comb begin
      par_ok_c = ((^sr) == sr_par);
   end
`else
   logic unused_sr_par;
   assign unused_sr_par = sr_par;

   // Parity checking disabled: every capture is accepted.
   always_comb begin
      par_ok_c = 1'b1;
   end
`endif

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_addr_c;
   logic [ENT_W-1:0] head_c;
   logic [IR_W-1:0]  head_ir_c;
   logic             full_c;
   logic             pop_c;
   logic             wr_ok_c;
   logic             ovf_set_c;
   logic             perr_set_c;

   // FIFO control: flush happens before the write; a pop frees a slot for a
   // same-cycle write even when full.
   always_comb begin
      head_c     = mem[rd_ptr];
      head_ir_c  = head_c[ENT_W-1:DATA_W];
      full_c     = (cmd_level == LVL_W'(FIFO_DEPTH));
      pop_c      = (cmd_level != '0) & cmd_ready;
      perr_set_c = udr_pulse_c & ~par_ok_c;
      wr_ok_c    = udr_pulse_c & par_ok_c & (uir_pulse_c | ~full_c | pop_c);
      ovf_set_c  = udr_pulse_c & par_ok_c & ~uir_pulse_c & full_c & ~pop_c;
      wr_addr_c  = uir_pulse_c ? '0 : wr_ptr;
   end

   // Entry storage; contents are don't-care while unoccupied, so no reset.
   always_ff @(posedge clk) begin
      if (wr_ok_c) begin
         mem[wr_addr_c] <= {ir_in, sr};
      end
   end

   // Pointers and occupancy; flush restarts the FIFO at slot 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cmd_level <= '0;
      end else if (uir_pulse_c) begin
         rd_ptr    <= '0;
         wr_ptr    <= wr_ok_c ? PTR_W'(1) : '0;
         cmd_level <= wr_ok_c ? LVL_W'(1) : '0;
      end else begin
         if (wr_ok_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_ok_c, pop_c})
            2'b10:   cmd_level <= cmd_level + LVL_W'(1);
            2'b01:   cmd_level <= cmd_level - LVL_W'(1);
            default: cmd_level <= cmd_level;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Dispatch outputs
   // ------------------------------------------------------------------

   // Load jdo/jir on a pop and raise one bit of the selected pulse vector.
   always_ff @(posedge clk) begin
      if (reset) begin
         jdo            <= '0;
         jir            <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         uir_pulse      <= 1'b0;
      end else begin
         take_action    <= '0;
         take_no_action <= '0;
         uir_pulse      <= uir_pulse_c;
         if (pop_c) begin
            jdo <= head_c[DATA_W-1:0];
            jir <= head_ir_c;
            if (head_c[ACTION_BIT]) begin
               take_action <= NV'(1) << head_ir_c;
            end else begin
               take_no_action <= NV'(1) << head_ir_c;
            end
         end
      end
   end

   // Sticky overflow; a new set beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (ovf_set_c) begin
         overflow <= 1'b1;
      end else if (err_clr) begin
         overflow <= 1'b0;
      end
   end

`ifdef DBG_CMD_PARITY_EN
   // Sticky parity error; a new set beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         parity_err <= 1'b0;
      end else if (perr_set_c) begin
         parity_err <= 1'b1;
      end else if (err_clr) begin
         parity_err <= 1'b0;
      end
   end
`else
   logic unused_perr_set;
   assign unused_perr_set = perr_set_c;
   assign parity_err      = 1'b0;
`endif

endmodule

// File: doc/mehdi_debug_cmd_dispatch.md
Name: mehdi_debug_cmd_dispatch

Overview:
- System-clock side of a parametrised debug slave. Receives update-DR and update-IR strobes that arrive asynchronously from the JTAG virtual-TAP domain, together with the scan register and IR.
- Synchronises the strobes, buffers captured commands in a FIFO, and dispatches them one at a time.
- Each dispatch presents the data word on jdo and pulses a one-hot take_action or take_no_action line, indexed by IR.
- Successor to the fixed 2-bit-IR / 38-bit, unbuffered sysclk capture stage; feeds the CPU OCI break, ocimem and trace-control logic.

Parameters:
- DATA_W, 38, scan register / jdo width.
- IR_W, 2, IR width; dispatch vectors are 2**IR_W wide.
- FIFO_DEPTH, 4, command buffer entries; power of two, at least 2.
- SYNC_STAGES, 2, synchroniser flops per strobe; at least 2.
- ACTION_BIT, 37, sr bit that selects take_action (1) or take_no_action (0).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- udr_async  in  1  update-DR level from the JTAG domain. Asynchronous; stays high at least SYNC_STAGES+1 clk periods.
- uir_async  in  1  update-IR level. Asynchronous; same minimum high time.
- ir_in  in  IR_W  IR value. Stable while udr_async or uir_async is high.
- sr  in  DATA_W  scan register. Stable while udr_async is high.
- sr_par  in  1  even parity over sr; used only with the optional feature.
- cmd_ready  in  1  consumer accepts a dispatch this cycle.
- err_clr  in  1  clears the sticky error flags.
- jdo  out  DATA_W  data word of the last dispatched command.
- jir  out  IR_W  IR of the last dispatched command.
- take_action  out  2**IR_W  one-cycle one-hot pulse.
- take_no_action  out  2**IR_W  one-cycle one-hot pulse.
- uir_pulse  out  1  one-cycle pulse per synchronised update-IR.
- cmd_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: a command was dropped because the FIFO was full.
- parity_err  out  1  sticky: a command was dropped on parity mismatch.

Behaviour:
- Reset:
  - jdo, jir, take_action, take_no_action, uir_pulse, cmd_level, overflow and parity_err are all 0.
  - FIFO empty; synchroniser flops 0.
  - Each strobe is disarmed until it has been sampled low once after reset, so a level held high through reset yields no pulse.
  - A reset asserted mid-operation discards the FIFO contents and any in-flight strobe.
- Synchroniser:
  - SYNC_STAGES flops per strobe, then a rising-edge detector.
  - One internal pulse per rising edge, regardless of how long the level stays high.
- Capture:
  - On a udr pulse, {ir_in, sr} is written to the FIFO in the same edge.
  - With SYNC_STAGES=2 and udr_async first sampled high at edge 1, the write occurs at edge 3.
- Dispatch:
  - At any edge where the FIFO is non-empty and cmd_ready=1: pop the head, load jdo and jir, and assert exactly one bit, either take_action[ir] (entry bit ACTION_BIT=1) or take_no_action[ir] (bit=0), for exactly one cycle.
  - Minimum end-to-end latency: outputs valid after edge SYNC_STAGES+2, i.e. edge 4 for the default.
- Hold: while cmd_ready=0 or the FIFO is empty, jdo and jir hold their values and both pulse vectors are 0. Back-to-back dispatches, one per cycle, are allowed.
- Update-IR:
  - On a uir pulse, uir_pulse is high one cycle and the FIFO is flushed, discarding stale commands.
  - jdo and jir are not cleared.
- Simultaneous events:
  - uir and udr pulses in the same cycle: flush takes effect first, then the write, so cmd_level=1 afterwards.
  - Write and pop in the same cycle: occupancy unchanged, and the write is accepted even when full.
  - Flush and pop in the same cycle: the head is dispatched; the rest is flushed.
- Full: a write to a full FIFO with no simultaneous pop is dropped and overflow is set.
- Error flags: overflow and parity_err are cleared by err_clr or reset. If a set and err_clr coincide, the set wins.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Occupancy is tracked by the separate cmd_level counter.

Optional Feature:
- Macro DBG_CMD_PARITY_EN.
- Defined:
  - At capture, compare XOR(sr) with sr_par.
  - On mismatch, drop the command (no FIFO write) and set parity_err.
  - The parity check takes precedence over the full check.
- Undefined: sr_par is ignored and parity_err is tied to 0.

Test Plan:
- Basic dispatch:
  - Stimulus: reset, then cmd_ready=1, ir_in=2'b01, sr=38'h20_0000_00AB (bit37=1), raise udr_async for 4 cycles.
  - Response: take_action=4'b0010 for exactly one cycle after edge 4; jdo=38'h20_0000_00AB; jir=1.
- No-action and buffering:
  - Stimulus: cmd_ready=0, three captures with ir=0, 2, 3, all bit37=0.
  - Response: cmd_level=3. Then cmd_ready=1 gives take_no_action pulses 0001, 0100, 1000 on consecutive cycles.
- Overflow:
  - Stimulus: cmd_ready=0, 5 captures with FIFO_DEPTH=4.
  - Response: cmd_level=4 and overflow=1; the fifth word is never dispatched. err_clr clears overflow.
- Flush and coincidence:
  - Stimulus: 2 commands queued, then uir_async and udr_async rise together.
  - Response: uir_pulse for one cycle; cmd_level=1; only the new command is dispatched.
- Reset behaviour:
  - Stimulus: udr_async held high across reset release.
  - Response: no dispatch. A low sample followed by a re-rise produces exactly one dispatch.
- Parity (DBG_CMD_PARITY_EN defined):
  - Stimulus: capture with sr=38'h1 and sr_par=0.
  - Response: parity_err=1 and cmd_level stays 0. With sr_par=1 the command dispatches normally.
